// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES types, constants and forward S-box table
package aes_pkg;

  typedef logic [127:0] state_t;

  localparam int n_bytes = 16;

  // FIPS-197 forward S-box, indexed by input byte
  localparam logic [7:0] sbox_table [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

endpackage

// File: rtl/sub_bytes_if.sv
// rtl/sub_bytes_if.sv - valid-qualified state in/out bundle for sub_bytes
interface sub_bytes_if;
  import aes_pkg::*;

  logic   in_valid;
  state_t in;
  logic   out_valid;
  state_t out;

  modport master (output in_valid, output in, input out_valid, input out);
  modport slave  (input in_valid, input in, output out_valid, output out);

endinterface

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational single-byte forward S-box lookup
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in,
  output logic [7:0] out
);

  assign out = sbox_table[in];

endmodule

// File: rtl/sub_bytes.sv
// rtl/sub_bytes.sv - AES SubBytes over a full 128-bit state, one-cycle latency
module sub_bytes
  import aes_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  sub_bytes_if.slave bus
);

  state_t sub;

  for (genvar i = 0; i < n_bytes; i++) begin : g_lane
    aes_sbox u_sbox (
      .in  (bus.in[8*i +: 8]),
      .out (sub[8*i +: 8])
    );
  end

  // out holds its last value on idle cycles; only out_valid drops
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out       <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.out <= sub;
      end
    end
  end

endmodule

// File: tb/tb_sub_bytes.sv
// tb/tb_sub_bytes.sv - randomized self-checking bench for sub_bytes against a GF(2^8) model
module tb_sub_bytes;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] ref_sbox [0:255];

  sub_bytes_if bus ();

  sub_bytes dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  // inverse by search, then the affine map with constant 0x63
  function automatic logic [7:0] model_sbox(input logic [7:0] a);
    logic [7:0] inv = 8'h00;
    logic [7:0] c = 8'h63;
    logic [7:0] s;
    for (int b = 1; b < 256; b++)
      if (a != 0 && gf_mul(a, 8'(b)) == 8'h01) inv = 8'(b);
    for (int i = 0; i < 8; i++)
      s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
    return s;
  endfunction

  function automatic logic [127:0] model_state(input logic [127:0] st);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = ref_sbox[st[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rand_state();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(input logic v, input logic [127:0] d);
    bus.in_valid = v;
    bus.in       = d;
    step();
  endtask

  initial begin
    logic [127:0] exp_out;
    logic [127:0] d;
    logic [127:0] inc;
    logic [255:0] seen;
    int fixed_pts;

    for (int a = 0; a < 256; a++) ref_sbox[a] = model_sbox(8'(a));

    // reset with a concurrent transfer that must be discarded
    rst = 1'b1;
    xfer(1'b1, {16{8'h53}});
    check("rst_out", bus.out, 128'h0);
    check("rst_valid", {127'h0, bus.out_valid}, 128'h0);

    rst = 1'b0;
    xfer(1'b1, 128'h00000101030307070f0f1f1f3f3f6f8f);
    check("vec1_out", bus.out, 128'h63637c7c7b7bc5c57676c0c07575a873);
    check("vec1_valid", {127'h0, bus.out_valid}, 128'h1);
    xfer(1'b1, 128'h0c2c341c9ca0fe14c90d2881a92d7721);
    check("vec2_out", bus.out, 128'hfe71189cdee0bbfaddd7340cd3d8f5fd);
    check("vec2_valid", {127'h0, bus.out_valid}, 128'h1);

    for (int k = 0; k < 3; k++) begin
      xfer(1'b0, rand_state());
      check("idle_valid", {127'h0, bus.out_valid}, 128'h0);
      check("idle_hold", bus.out, 128'hfe71189cdee0bbfaddd7340cd3d8f5fd);
    end

    xfer(1'b1, {16{8'h00}});
    check("all00", bus.out, {16{8'h63}});
    xfer(1'b1, {16{8'hff}});
    check("allff", bus.out, {16{8'h16}});
    xfer(1'b1, {16{8'h53}});
    check("all53", bus.out, {16{8'hed}});
    xfer(1'b1, {16{8'h01}});
    check("all01", bus.out, {16{8'h7c}});
    xfer(1'b1, {16{8'h8f}});
    check("all8f", bus.out, {16{8'h73}});
    for (int i = 0; i < 16; i++) inc[8*i +: 8] = 8'(15 - i);
    xfer(1'b1, inc);
    check("ramp", bus.out, model_state(inc));

    // every value through every lane, back-to-back
    seen = '0;
    fixed_pts = 0;
    for (int k = 0; k < 256; k++) begin
      for (int i = 0; i < 16; i++) d[8*i +: 8] = 8'((k + 17*i) % 256);
      xfer(1'b1, d);
      check("sweep", bus.out, model_state(d));
      check("sweep_valid", {127'h0, bus.out_valid}, 128'h1);
      for (int i = 0; i < 16; i++)
        if (bus.out[8*i +: 8] == d[8*i +: 8]) fixed_pts++;
      seen[bus.out[7:0]] = 1'b1;
    end
    check("fixed_points", 128'(fixed_pts), 128'h0);
    check("bijection", 128'($countones(seen)), 128'd256);

    // random valid pattern against the model
    exp_out = bus.out;
    for (int k = 0; k < 300; k++) begin
      logic v;
      v = 1'($urandom_range(0, 1));
      d = rand_state();
      xfer(v, d);
      if (v) exp_out = model_state(d);
      check("rand_out", bus.out, exp_out);
      check("rand_valid", {127'h0, bus.out_valid}, {127'h0, v});
    end

    // mid-stream reset, then first valid after deassertion
    rst = 1'b1;
    xfer(1'b1, rand_state());
    check("rst2_out", bus.out, 128'h0);
    check("rst2_valid", {127'h0, bus.out_valid}, 128'h0);
    rst = 1'b0;
    xfer(1'b0, rand_state());
    check("post_rst_idle", {127'h0, bus.out_valid}, 128'h0);
    check("post_rst_hold", bus.out, 128'h0);
    d = rand_state();
    xfer(1'b1, d);
    check("post_rst_first", bus.out, model_state(d));
    check("post_rst_valid", {127'h0, bus.out_valid}, 128'h1);
    xfer(1'b0, rand_state());
    check("single_pulse", {127'h0, bus.out_valid}, 128'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
